// File: rtl/dram_tester_pkg.sv
// Shared types and pattern generator for the DRAM pattern tester.
// Pure combinational helpers; no latency, no flow control.
// Wishbone backpressure is handled by the tester itself.
package dram_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WR,
        RD,
        DONE
    } state_t;

    localparam int unsigned ADDR_STRIDE_DEF = 128;
    localparam int          PAT_MAX_W       = 1024;

    // Result is PAT_MAX_W wide; callers truncate to their word size.
    function automatic logic [PAT_MAX_W-1:0] pattern(
        input logic [31:0] idx,
        input logic [31:0] seed,
        input int          word_size
    );
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int k = 0; k < PAT_MAX_W / 32; k++) begin
            if (k < word_size / 32)
                p[k*32 +: 32] = seed ^ idx ^ {8'(k), 24'h0};
        end
        return p;
    endfunction

endpackage

// File: rtl/dram_pattern_tester.sv
// Wishbone initiator: writes a seeded pattern over NUM_WORDS, reads back, counts mismatches.
// Latency: request issued one cycle after entering WR/RD or after each ack; one outstanding txn.
// Backpressure: waits on ack_i (forever, or TIMEOUT_CYC cycles when DRAM_TESTER_TIMEOUT_EN is defined).
module dram_pattern_tester
    import dram_tester_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 256,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_STRIDE = ADDR_STRIDE_DEF,
    parameter logic [31:0] SEED        = 32'hA5A5_0F0F,
    parameter int unsigned ERR_CNT_W   = 16
`ifdef DRAM_TESTER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 initialized_i,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [31:0]          addr_o,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic [31:0]          first_err_addr_o
`ifdef DRAM_TESTER_TIMEOUT_EN
    ,
    output logic                 timeout_o
`endif
);

    state_t                 state_q, state_d;
    logic                   req_q;
    logic [31:0]            idx_q;
    logic [31:0]            addr_q;
    logic [WORD_SIZE-1:0]   data_q;
    logic [ERR_CNT_W-1:0]   err_q;
    logic [31:0]            first_q;
    logic                   acked;
    logic                   last;
    logic                   tmo_hit;
    logic                   to_flag;
    logic [31:0]            addr_cur;
    logic [WORD_SIZE-1:0]   pat_cur;

    assign acked    = req_q & ack_i;
    assign last     = (idx_q == 32'(NUM_WORDS - 1));
    assign addr_cur = BASE_ADDR + idx_q * 32'(ADDR_STRIDE);
    assign pat_cur  = WORD_SIZE'(pattern(idx_q, SEED, int'(WORD_SIZE)));

`ifdef DRAM_TESTER_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        timeout_q;
    assign tmo_hit   = req_q & ~ack_i & (tmo_q == 32'(TIMEOUT_CYC - 1));
    assign to_flag   = timeout_q;
    assign timeout_o = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign to_flag = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i) state_d = WAIT_INIT;
            WAIT_INIT:  if (initialized_i) state_d = WR;
            WR:         if (acked && last) state_d = RD;
                        else if (tmo_hit) state_d = DONE;
            RD:         if ((acked && last) || tmo_hit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_o            = req_q & ~ack_i;
        stb_o            = req_q & ~ack_i;
        we_o             = req_q & (state_q == WR);
        addr_o           = addr_q;
        data_o           = data_q;
        busy_o           = (state_q == WAIT_INIT) || (state_q == WR) || (state_q == RD);
        done_o           = (state_q == DONE);
        pass_o           = (state_q == DONE) && (err_q == '0) && !to_flag;
        err_count_o      = err_q;
        first_err_addr_o = first_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= '0;
            first_q   <= '1;
`ifdef DRAM_TESTER_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        idx_q     <= '0;
                        err_q     <= '0;
                        first_q   <= '1;
`ifdef DRAM_TESTER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                WR, RD: begin
                    // Issuing only from req_q=0 gives the one-cycle gap after every ack.
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= addr_cur;
                        data_q <= (state_q == WR) ? pat_cur : '0;
`ifdef DRAM_TESTER_TIMEOUT_EN
                        tmo_q  <= '0;
`endif
                    end else if (ack_i) begin
                        req_q <= 1'b0;
                        idx_q <= last ? '0 : idx_q + 32'd1;
                        if (state_q == RD && data_i != pat_cur) begin
                            if (err_q != '1) err_q <= err_q + 1'b1;
                            if (err_q == '0) first_q <= addr_q;
                        end
                    end
`ifdef DRAM_TESTER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
